vfm_icl_arbiter: RTL and testbench

Inter-core link arbiter for the multicore processor build. Worker cores each post one 14-bit word at a time over their Out ack/data port pair. The block grants one worker at a time using round-robin order. It then forwards the word, tagged with its source index, to core 0 over a single In ack/data pair, and returns completion to the worker once core 0 acknowledges. With this block, core 0 polls one mailbox instead of one link per worker. It sits in the top level between the worker cores' Out1/Out2 ports and core 0's In1/In2 ports.

---
 rtl/vfm_icl_pkg.sv | 20 ++
 rtl/vfm_rr_pick.sv | 24 ++
 rtl/vfm_icl_arbiter.sv | 88 ++++++++
 tb/tb_vfm_icl_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vfm_icl_pkg.sv
// rtl/vfm_icl_pkg.sv - shared types and constants for the inter-core link arbiter
package vfm_icl_pkg;

  localparam int ICL_DATA_W = 14;
  localparam int ICL_SRC_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } icl_state_t;

  // Next index after idx in a ring of n entries.
  function automatic logic [ICL_SRC_W-1:0] wrap_inc(input logic [ICL_SRC_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/vfm_rr_pick.sv
// rtl/vfm_rr_pick.sv - combinational round-robin picker: first pending index at or after ptr
module vfm_rr_pick
  import vfm_icl_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]   pending,
  input  logic [ICL_SRC_W-1:0] ptr,
  output logic [ICL_SRC_W-1:0] grant,
  output logic                 any_valid
);

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    grant     = '0;
    any_valid = |pending;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pending[(int'(ptr) + k) % NUM_REQ]) begin
        grant = ICL_SRC_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/vfm_icl_arbiter.sv
// rtl/vfm_icl_arbiter.sv - round-robin toggle-handshake arbiter funnelling worker words to core 0
module vfm_icl_arbiter
  import vfm_icl_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = ICL_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      Clock_pin,
  input  logic                      Reset_pin,
  input  logic [NUM_REQ-1:0]        src_tog,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]        src_done,
  output logic [DATA_W-1:0]         dst_data,
  output logic [ICL_SRC_W-1:0]      dst_src,
  output logic                      dst_tog,
  input  logic                      dst_ack,
  output logic                      busy,
  output logic                      timeout
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  icl_state_t             state;
  logic [ICL_SRC_W-1:0]   ptr;
  logic [NUM_REQ-1:0]     seen_tog;
  logic [CNT_W-1:0]       wait_cnt;
  logic [NUM_REQ-1:0]     pending;
  logic [ICL_SRC_W-1:0]   pick;
  logic                   any_valid;

  assign pending = src_tog ^ seen_tog;

  vfm_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .pending   (pending),
    .ptr       (ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  // dst_src doubles as the record of the granted worker while in WAIT.
  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      state    <= IDLE;
      ptr      <= '0;
      seen_tog <= '0;
      wait_cnt <= '0;
      src_done <= '0;
      dst_data <= '0;
      dst_src  <= '0;
      dst_tog  <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            dst_data       <= src_data[int'(pick)*DATA_W +: DATA_W];
            dst_src        <= pick;
            seen_tog[pick] <= src_tog[pick];
            dst_tog        <= ~dst_tog;
            wait_cnt       <= '0;
            busy           <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (dst_ack == dst_tog) begin
            src_done[dst_src] <= ~src_done[dst_src];
            ptr               <= wrap_inc(dst_src, NUM_REQ);
            busy              <= 1'b0;
            state             <= IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt + 1'b1 == CNT_MAX) begin
              timeout <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfm_icl_arbiter.sv
// tb/tb_vfm_icl_arbiter.sv - self-checking bench: vector table, corner sequences, randomized model run
module tb_vfm_icl_arbiter;
  import vfm_icl_pkg::*;

  localparam int N  = 3;
  localparam int DW = 14;
  localparam int TO = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_tog = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_done;
  logic [DW-1:0]   dst_data;
  logic [2:0]      dst_src;
  logic            dst_tog;
  logic            dst_ack = 1'b0;
  logic            busy;
  logic            timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vfm_icl_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Clock_pin (clk),
    .Reset_pin (rst),
    .src_tog   (src_tog),
    .src_data  (src_data),
    .src_done  (src_done),
    .dst_data  (dst_data),
    .dst_src   (dst_src),
    .dst_tog   (dst_tog),
    .dst_ack   (dst_ack),
    .busy      (busy),
    .timeout   (timeout)
  );

  typedef struct {
    logic            rst;
    logic [N-1:0]    tog;
    logic            ack;
    logic [N*DW-1:0] data;
    logic            e_tog;
    logic [2:0]      e_src;
    logic [DW-1:0]   e_data;
    logic [N-1:0]    e_done;
    logic            e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [N-1:0] t, input logic a, input logic [N*DW-1:0] d,
                     input logic et, input logic [2:0] es, input logic [DW-1:0] ed,
                     input logic [N-1:0] edn, input logic eb);
    vec_t v;
    v.rst = r; v.tog = t; v.ack = a; v.data = d;
    v.e_tog = et; v.e_src = es; v.e_data = ed; v.e_done = edn; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input logic [DW-1:0] w);
    src_data[i*DW +: DW] = w;
    src_tog[i] = ~src_tog[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_tog = '0;
    dst_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Randomized-run reference: per-worker posted words, round-robin by ring distance.
  bit            posted [N];
  bit            wbusy  [N];
  logic [DW-1:0] word   [N];
  int            m_rr, m_g, m_waits, best, idx;
  bit            m_serv, m_to;
  logic          m_tog;
  logic [DW-1:0] m_data;
  logic [2:0]    m_src;
  logic [N-1:0]  m_done;
  logic [31:0]   rnd;

  localparam logic [N*DW-1:0] D1 = {14'h000, 14'h1A5, 14'h000};
  localparam logic [N*DW-1:0] D2 = {14'h030, 14'h020, 14'h010};

  initial begin
    add(1, 3'b000, 0, D1, 0, 0, 14'h000, 3'b000, 0);
    add(0, 3'b000, 0, D1, 0, 0, 14'h000, 3'b000, 0);
    add(0, 3'b010, 0, D1, 1, 1, 14'h1A5, 3'b000, 1);
    add(0, 3'b010, 0, D1, 1, 1, 14'h1A5, 3'b000, 1);
    add(0, 3'b010, 1, D1, 1, 1, 14'h1A5, 3'b010, 0);
    add(0, 3'b010, 1, D1, 1, 1, 14'h1A5, 3'b010, 0);
    add(1, 3'b000, 0, D2, 0, 0, 14'h000, 3'b000, 0);
    add(0, 3'b000, 0, D2, 0, 0, 14'h000, 3'b000, 0);
    add(0, 3'b111, 0, D2, 1, 0, 14'h010, 3'b000, 1);
    add(0, 3'b111, 1, D2, 1, 0, 14'h010, 3'b001, 0);
    add(0, 3'b111, 1, D2, 0, 1, 14'h020, 3'b001, 1);
    add(0, 3'b111, 0, D2, 0, 1, 14'h020, 3'b011, 0);
    add(0, 3'b111, 0, D2, 1, 2, 14'h030, 3'b011, 1);
    add(0, 3'b111, 1, D2, 1, 2, 14'h030, 3'b111, 0);
    add(0, 3'b111, 1, D2, 1, 2, 14'h030, 3'b111, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      src_tog  = vecs[i].tog;
      dst_ack  = vecs[i].ack;
      src_data = vecs[i].data;
      step();
      check($sformatf("vec%0d", i), {timeout, dst_tog, dst_src, dst_data, src_done, busy},
            {1'b0, vecs[i].e_tog, vecs[i].e_src, vecs[i].e_data, vecs[i].e_done, vecs[i].e_busy});
    end

    // Fairness: worker 0 re-posts right after each completion while worker 2 waits.
    do_reset();
    post(0, 14'h111);
    post(2, 14'h222);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("fair_grant%0d", k), {busy, dst_src}, {1'b1, (k % 2 == 0) ? 3'd0 : 3'd2});
      dst_ack = dst_tog;
      step();
      check($sformatf("fair_done%0d", k), busy, 1'b0);
      post((k % 2 == 0) ? 0 : 2, DW'(k + 5));
    end

    // Timeout: ack withheld; fires exactly TO cycles into WAIT and stays sticky.
    do_reset();
    post(1, 14'h155);
    step();
    check("to_grant", {dst_tog, busy, dst_src}, {1'b1, 1'b1, 3'd1});
    repeat (TO - 1) step();
    check("to_before", {timeout, busy}, 2'b01);
    step();
    check("to_set", {timeout, busy}, 2'b11);
    repeat (5) step();
    check("to_hold", {timeout, busy, src_done}, {1'b1, 1'b1, 3'b000});
    dst_ack = dst_tog;
    step();
    check("to_late_ack", {src_done, busy, timeout}, {3'b010, 1'b0, 1'b1});

    // Reset mid-WAIT clears everything without waiting for a clock edge.
    post(0, 14'h2AA);
    step();
    check("rst_pre_busy", {busy, dst_src, dst_data}, {1'b1, 3'd0, 14'h2AA});
    rst = 1'b1;
    src_tog = '0;
    dst_ack = 1'b0;
    #2;
    check("rst_async", {dst_tog, dst_src, dst_data, src_done, busy, timeout}, 23'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("rst_no_grant", {dst_tog, busy}, 2'b00);

    // A toggle already high at reset release is a request.
    rst = 1'b1;
    src_tog = 3'b100;
    step();
    rst = 1'b0;
    step();
    check("rel_high_tog", {dst_tog, dst_src, busy}, {1'b1, 3'd2, 1'b1});

    // Double toggle from worker 2 while worker 0 is served cancels its request.
    do_reset();
    post(0, 14'h0AB);
    step();
    check("dbl_grant0", {dst_src, busy}, {3'd0, 1'b1});
    post(2, 14'h3CD);
    step();
    src_tog[2] = ~src_tog[2];
    step();
    dst_ack = dst_tog;
    step();
    check("dbl_done0", {src_done, busy}, {3'b001, 1'b0});
    repeat (3) step();
    check("dbl_no_grant", {dst_tog, dst_src, busy, src_done}, {1'b1, 3'd0, 1'b0, 3'b001});

    // Randomized run against the reference.
    do_reset();
    for (int i = 0; i < N; i++) begin
      posted[i] = 0; wbusy[i] = 0; word[i] = '0;
    end
    m_rr = 0; m_g = 0; m_waits = 0; m_serv = 0; m_to = 0;
    m_tog = 0; m_data = '0; m_src = '0; m_done = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!wbusy[i] && $urandom_range(0, 3) == 0) begin
          rnd = $urandom;
          word[i] = rnd[DW-1:0];
          post(i, word[i]);
          wbusy[i] = 1;
          posted[i] = 1;
        end
      end
      if (dst_tog != dst_ack && $urandom_range(0, 2) == 0) dst_ack = dst_tog;
      @(posedge clk);
      if (m_serv) begin
        if (dst_ack == m_tog) begin
          m_done[m_g] = ~m_done[m_g];
          m_rr = (m_g + 1) % N;
          m_serv = 0;
          wbusy[m_g] = 0;
        end else begin
          if (m_waits < TO) m_waits++;
          if (m_waits == TO) m_to = 1;
        end
      end else begin
        best = -1;
        for (int d = 0; d < N; d++) begin
          idx = (m_rr + d) % N;
          if (best < 0 && posted[idx]) best = idx;
        end
        if (best >= 0) begin
          m_g = best;
          posted[best] = 0;
          m_tog = ~m_tog;
          m_data = word[best];
          m_src = 3'(best);
          m_serv = 1;
          m_waits = 0;
        end
      end
      #1;
      check($sformatf("rand%0d", cyc), {timeout, dst_tog, dst_src, dst_data, src_done, busy},
            {m_to, m_tog, m_src, m_data, m_done, m_serv});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
